// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data SRAM arbiter.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DATA_ACC  = 2'd1,
        ST_FETCH_ACC = 2'd2
    } state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_e;

    localparam int unsigned WAIT_CYCLES_DEFAULT = 3;
    localparam int unsigned CNT_W               = 4;
endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// Loadable down-counter that times one SRAM access; zero marks the final access cycle.
module wait_counter
    import mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port SRAM between the fetch stage and the data-memory stage,
// alternating grants on contention and returning registered data with a one-cycle ready.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        freeze,
    output logic        sram_en,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    grant_e      last_q, last_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic        we_q, we_d, if_ready_q, if_ready_d, dm_ready_q, dm_ready_d;
    logic        dm_pending, if_pending, grant_data, grant_fetch;
    logic        cnt_load, cnt_en, cnt_zero;
    logic        unused_addr_lsbs;

    // A request whose ready is pulsing this cycle is already served and must not re-grant.
    assign dm_pending  = (dm_read | dm_write) & ~dm_ready_q;
    assign if_pending  = if_req & ~if_ready_q;
    assign grant_data  = dm_pending & (~if_pending | (last_q == GNT_FETCH));
    assign grant_fetch = if_pending & ~grant_data;

    wait_counter u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    state_d = ST_DATA_ACC;
                end else if (grant_fetch) begin
                    state_d = ST_FETCH_ACC;
                end
            end
            ST_DATA_ACC, ST_FETCH_ACC: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        last_d     = last_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    addr_d   = {dm_addr[31:2], 2'b00};
                    wdata_d  = dm_wdata;
                    we_d     = dm_write;
                    cnt_load = 1'b1;
                end else if (grant_fetch) begin
                    addr_d   = {if_addr[31:2], 2'b00};
                    we_d     = 1'b0;
                    cnt_load = 1'b1;
                end
            end
            ST_DATA_ACC: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    dm_ready_d = 1'b1;
                    last_d     = GNT_DATA;
                    if (!we_q) begin
                        dm_rdata_d = sram_rdata;
                    end
                end
            end
            ST_FETCH_ACC: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    if_ready_d = 1'b1;
                    if_rdata_d = sram_rdata;
                    last_d     = GNT_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            last_q     <= GNT_FETCH;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            last_q     <= last_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
        end
    end

    assign sram_en    = (state_q != ST_IDLE);
    assign sram_we    = (state_q == ST_DATA_ACC) & we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign if_rdata   = if_rdata_q;
    assign dm_rdata   = dm_rdata_q;
    assign if_ready   = if_ready_q;
    assign dm_ready   = dm_ready_q;
    assign freeze     = dm_pending;

    assign unused_addr_lsbs = ^{if_addr[1:0], dm_addr[1:0]};
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter, plus a directed check of a WAIT_CYCLES=1 instance.
module tb_mem_arbiter;
    localparam int W = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, if_req, dm_read, dm_write;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, sram_addr, sram_wdata, sram_rdata;
    logic        if_ready, dm_ready, freeze, sram_en, sram_we;

    logic        rst1, if_req1, dm_read1, dm_write1;
    logic [31:0] if_addr1, dm_addr1, dm_wdata1;
    logic [31:0] if_rdata1, dm_rdata1, sram_addr1, sram_wdata1, sram_rdata1;
    logic        if_ready1, dm_ready1, freeze1, sram_en1, sram_we1;

    function automatic logic [31:0] sram_model(input logic [31:0] a);
        if (a == 32'h0000_0104) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    assign sram_rdata  = sram_model(sram_addr);
    assign sram_rdata1 = sram_model(sram_addr1);

    mem_arbiter #(.WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready), .freeze(freeze),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    mem_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst1), .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1),
        .if_ready(if_ready1), .dm_read(dm_read1), .dm_write(dm_write1), .dm_addr(dm_addr1),
        .dm_wdata(dm_wdata1), .dm_rdata(dm_rdata1), .dm_ready(dm_ready1), .freeze(freeze1),
        .sram_en(sram_en1), .sram_we(sram_we1), .sram_addr(sram_addr1),
        .sram_wdata(sram_wdata1), .sram_rdata(sram_rdata1)
    );

    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        int          t;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          last_fetch = 1'b1;
    logic [31:0] dm_last = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: bus expectations derive from the front transaction's ready cycle.
    always @(negedge clk) begin : mon
        exp_t f;
        bit   have;
        bit   exp_en;
        have   = (q.size() > 0);
        exp_en = 1'b0;
        if (have) begin
            f      = q[0];
            exp_en = (cyc >= f.t - W) && (cyc < f.t);
        end
        chk("sram_en", {31'b0, sram_en}, {31'b0, exp_en});
        if (exp_en) begin
            chk("sram_addr", sram_addr, f.addr);
            chk("sram_we", {31'b0, sram_we}, {31'b0, f.we});
            if (f.we) chk("sram_wdata", sram_wdata, f.wdata);
        end
        chk("freeze", {31'b0, freeze},
            {31'b0, (dm_read | dm_write) & ~(have && f.is_data && f.t == cyc)});
        chk("ready_exclusive", {31'b0, if_ready & dm_ready}, 32'd0);
        if (dm_ready || if_ready) begin
            if (!have) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: got if_ready=%0b dm_ready=%0b expected none (cycle %0d)",
                         if_ready, dm_ready, cyc);
            end else begin
                void'(q.pop_front());
                chk("ready_kind", {31'b0, dm_ready}, {31'b0, f.is_data});
                chk("ready_cycle", cyc, f.t);
                if (f.is_data) chk("dm_rdata", dm_rdata, f.data);
                else           chk("if_rdata", if_rdata, f.data);
            end
        end else if (have && cyc > f.t) begin
            checks++;
            failures++;
            $display("FAIL missing_ready: got no ready expected one at cycle %0d (now %0d)", f.t, cyc);
            void'(q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is positioned just after a rising edge; requests appear in the current cycle.
    task automatic run_txn(input bit d_on, input bit d_rd, input bit d_wr, input bit f_on,
                           input logic [31:0] da, input logic [31:0] wd, input logic [31:0] fa,
                           input bit drop);
        int   c, t_d, t_f, t_end;
        bit   data_first;
        exp_t e;
        c = cyc;
        dm_read  = d_on & d_rd;
        dm_write = d_on & d_wr;
        dm_addr  = da;
        dm_wdata = wd;
        if_req   = f_on;
        if_addr  = fa;
        data_first = d_on && (!f_on || last_fetch);
        t_d = 0;
        t_f = 0;
        if (d_on) t_d = data_first ? c + W + 1 : c + 2 * (W + 1);
        if (f_on) t_f = data_first ? c + 2 * (W + 1) : c + W + 1;
        for (int k = 0; k < 2; k++) begin
            bit serve_data;
            serve_data = (k == 0) ? data_first : !data_first;
            if (serve_data && d_on) begin
                e.is_data = 1'b1;
                e.we      = d_wr;
                e.addr    = {da[31:2], 2'b00};
                e.wdata   = wd;
                if (!d_wr) dm_last = sram_model(e.addr);
                e.data    = dm_last;
                e.t       = t_d;
                q.push_back(e);
                last_fetch = 1'b0;
            end else if (!serve_data && f_on) begin
                e.is_data = 1'b0;
                e.we      = 1'b0;
                e.addr    = {fa[31:2], 2'b00};
                e.wdata   = '0;
                e.data    = sram_model(e.addr);
                e.t       = t_f;
                q.push_back(e);
                last_fetch = 1'b1;
            end
        end
        t_end = (t_d > t_f) ? t_d : t_f;
        while (cyc <= t_end) begin
            tick();
            if (drop && cyc == c + 2) begin
                dm_read  = 1'b0;
                dm_write = 1'b0;
                if_req   = 1'b0;
            end
            if (d_on && cyc == t_d + 1) begin
                dm_read  = 1'b0;
                dm_write = 1'b0;
            end
            if (f_on && cyc == t_f + 1) if_req = 1'b0;
        end
    endtask

    initial begin
        int   c;
        exp_t e;
        rst = 1'b1; if_req = 0; dm_read = 0; dm_write = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        rst1 = 1'b1; if_req1 = 0; dm_read1 = 0; dm_write1 = 0;
        if_addr1 = '0; dm_addr1 = '0; dm_wdata1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_readies", {30'b0, if_ready, dm_ready}, 32'd0);
        chk("rst_sram_ctl", {30'b0, sram_en, sram_we}, 32'd0);
        chk("rst_sram_addr", sram_addr, 32'd0);
        chk("rst_sram_wdata", sram_wdata, 32'd0);
        tick();
        rst = 1'b0;

        // Contention straight out of reset: data write first, then fetch.
        run_txn(1, 0, 1, 1, 32'h0000_2008, 32'hA5A5_0F0F, 32'h0000_1000, 0);
        tick();
        run_txn(1, 1, 0, 0, 32'h0000_0106, 32'h0, 32'h0, 0);
        tick();
        run_txn(0, 0, 0, 1, 32'h0, 32'h0, 32'h0000_3004, 1);
        for (int i = 0; i < 3; i++) run_txn(1, 1, 0, 1, 32'h0000_4000 + 32'(i * 4), 32'h0, 32'h0000_5000 + 32'(i * 8), 0);

        for (int i = 0; i < 60; i++) begin
            int          mode;
            bit          rd, wr;
            logic [31:0] da, wd, fa;
            mode = $urandom_range(0, 5);
            da   = $urandom;
            wd   = $urandom;
            fa   = $urandom;
            case ($urandom_range(0, 2))
                0:       begin rd = 1; wr = 0; end
                1:       begin rd = 0; wr = 1; end
                default: begin rd = 1; wr = 1; end
            endcase
            case (mode)
                0, 1, 2: run_txn(1, rd, wr, 0, da, wd, fa, 0);
                3:       run_txn(0, 0, 0, 1, da, wd, fa, 0);
                4:       run_txn(1, rd, wr, 1, da, wd, fa, 0);
                default: run_txn(~mode[0], rd, wr, mode[0], da, wd, fa, 1);
            endcase
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset during the second access cycle of a write; the held write is re-granted afterwards.
        tick();
        c = cyc;
        dm_write = 1'b1; dm_addr = 32'h0000_7778; dm_wdata = 32'h1357_9BDF;
        e.is_data = 1'b1; e.we = 1'b1; e.addr = 32'h0000_7778; e.wdata = 32'h1357_9BDF;
        e.data = dm_last; e.t = c + W + 1;
        q.push_back(e);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        dm_last = '0;
        last_fetch = 1'b1;
        e.data = '0;
        e.t = cyc + W + 1;
        q.push_back(e);
        while (cyc <= e.t) tick();
        dm_write = 1'b0;
        repeat (4) tick();
        chk("queue_drained", q.size(), 32'd0);

        // WAIT_CYCLES=1 instance: two-cycle latency, read+write treated as write.
        rst1 = 1'b0;
        dm_read1 = 1'b1; dm_write1 = 1'b1; dm_addr1 = 32'h2000_0013; dm_wdata1 = 32'hCAFE_0001;
        @(negedge clk);
        chk("w1_grant_en", {31'b0, sram_en1}, 32'd0);
        @(negedge clk);
        chk("w1_acc_ctl", {30'b0, sram_en1, sram_we1}, 32'd3);
        chk("w1_acc_addr", sram_addr1, 32'h2000_0010);
        chk("w1_acc_wdata", sram_wdata1, 32'hCAFE_0001);
        chk("w1_acc_ready", {31'b0, dm_ready1}, 32'd0);
        @(negedge clk);
        chk("w1_wr_ready", {30'b0, dm_ready1, sram_en1}, 32'd2);
        chk("w1_wr_rdata", dm_rdata1, 32'd0);
        tick();
        dm_write1 = 1'b0; dm_addr1 = 32'h0000_0048;
        @(negedge clk);
        @(negedge clk);
        chk("w1_rd_ctl", {30'b0, sram_en1, sram_we1}, 32'd2);
        @(negedge clk);
        chk("w1_rd_ready", {31'b0, dm_ready1}, 32'd1);
        chk("w1_rd_rdata", dm_rdata1, sram_model(32'h0000_0048));
        tick();
        dm_read1 = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 3, SHALL set the SRAM access length in cycles (legal 1..15).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 if_req  in  1  fetch-stage read request, held until if_ready.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_rdata  out  32  registered fetch data, valid while if_ready=1.
REQ-007 if_ready  out  1  one-cycle pulse marking fetch completion.
REQ-008 dm_read  in  1  data read request from the decoded mem_read, held until dm_ready.
REQ-009 dm_write  in  1  data write request from the decoded mem_write, held until dm_ready.
REQ-010 dm_addr  in  32  data byte address.
REQ-011 dm_wdata  in  32  store data.
REQ-012 dm_rdata  out  32  registered load data, valid while dm_ready=1.
REQ-013 dm_ready  out  1  one-cycle pulse marking data completion.
REQ-014 freeze  out  1  pipeline stall, combinational: (dm_read|dm_write) & ~dm_ready.
REQ-015 sram_en  out  1  SRAM access enable.
REQ-016 sram_we  out  1  SRAM write enable, valid only with sram_en.
REQ-017 sram_addr  out  32  word address {addr[31:2],2'b00}.
REQ-018 sram_wdata  out  32  write data.
REQ-019 sram_rdata  in  32  SRAM read data, valid in the final access cycle.

Function
REQ-020 FSM states SHALL be IDLE, DATA_ACC, FETCH_ACC.
REQ-021 In IDLE, the arbiter SHALL grant when any request is present:
  - data only: grant data.
  - fetch only: grant fetch.
  - both: grant the requester not served last (last_grant register; reset value = fetch, so data wins first).
REQ-022 On grant, the arbiter SHALL latch address, wdata and direction, and load the wait counter with WAIT_CYCLES-1.
REQ-023 During an access:
  - sram_en=1; sram_addr, sram_wdata and sram_we SHALL remain stable.
  - the counter SHALL decrement each cycle.
REQ-024 At counter 0:
  - capture sram_rdata into if_rdata or dm_rdata; a write SHALL leave dm_rdata unchanged.
  - pulse the matching ready for the next cycle.
  - return to IDLE and update last_grant.
REQ-025 Grant-to-ready latency SHALL be exactly WAIT_CYCLES+1 cycles; back-to-back accesses SHALL have one IDLE turnaround cycle.
REQ-026 dm_read and dm_write both high SHALL be treated as a write.
REQ-027 A request deasserted mid-access SHALL NOT abort the access; the ready pulse SHALL still occur.
REQ-028 Request inputs SHALL be sampled only in IDLE; changes during an access SHALL be ignored.
REQ-029 if_ready and dm_ready SHALL never be high in the same cycle.
REQ-030 Only fetch and data requesters exist; sram_we SHALL never assert for a fetch access.

Reset
REQ-031 While rst=1, the following SHALL hold:
  - state=IDLE, counter=0, last_grant=fetch.
  - sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
  - if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0.
REQ-032 Reset asserted mid-access SHALL abort the access at the next edge with no ready pulse.
REQ-033 The first grant SHALL be possible in the first cycle after rst falls.

Structure
REQ-034 A shared package SHALL hold the state encoding, the grant encoding and the WAIT_CYCLES default.
REQ-035 The down-counter SHALL be a sub-module wait_counter (load, enable, zero flag).
REQ-036 Target size is 120-400 lines of RTL; no memory array inside the block.

Verification
REQ-037 Data read only: dm_read=1, dm_addr=0x0000_0106, SRAM returns 0xDEAD_BEEF ->
  - sram_addr=0x0000_0104, sram_we=0 for 3 cycles.
  - dm_ready pulses on cycle 4 with dm_rdata=0xDEAD_BEEF.
  - freeze high until that cycle.
REQ-038 Simultaneous requests from reset: dm_write and if_req both high ->
  - data is served first (sram_we=1 for 3 cycles, dm_ready pulse).
  - fetch is granted after one IDLE cycle, if_ready pulses 4 cycles later.
REQ-039 Fairness: dm_read and if_req held continuously -> grants alternate data, fetch, data; no requester waits more than two accesses.
REQ-040 Drop mid-access: if_req deasserted in cycle 2 of a fetch -> access completes and if_ready still pulses once.
REQ-041 rst=1 in cycle 2 of a data write -> next cycle sram_en=0 with no dm_ready; after release, a held dm_write re-grants and completes normally.
REQ-042 WAIT_CYCLES=1 -> grant-to-ready = 2 cycles; dm_read and dm_write both high -> sram_we=1.
